// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with occupancy count, status flags and
// single-cycle overflow/underflow error pulses.
//
// Parameters
//   WIDTH          data word width in bits
//   DEPTH          address width; storage holds 2**DEPTH words
//   AFULL_THRESH   almost_full asserts when count >= this level (1..2**DEPTH)
//   AEMPTY_THRESH  almost_empty asserts when count <= this level (0..2**DEPTH-1)
//   FWFT           1 = first-word-fall-through read data, 0 = registered read
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   we / wdata     write request and write data
//   re             read request
//   rdata          read data (FWFT: head word; registered: last word read)
//   full, empty, almost_full, almost_empty   status flags
//   count          current occupancy, 0..2**DEPTH
//   overflow       one-cycle pulse after an edge that saw we while full
//   underflow      one-cycle pulse after an edge that saw re while empty
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = 2**DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             ENTRIES    = 2**DEPTH;
    localparam logic [DEPTH:0] AFULL_LVL  = (DEPTH+1)'(AFULL_THRESH);
    localparam logic [DEPTH:0] AEMPTY_LVL = (DEPTH+1)'(AEMPTY_THRESH);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the address bits coincide.
    logic [DEPTH:0]   wptr_q, wptr_d;
    logic [DEPTH:0]   rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [WIDTH-1:0] mem [ENTRIES];

    logic             full_w;
    logic             empty_w;
    logic [DEPTH:0]   count_w;
    logic             wr_en;
    logic             rd_en;

    // -----------------------------------------------------------------------
    // Status derived from the registered pointers only, so every flag and the
    // count describe the state before the coming edge.
    // -----------------------------------------------------------------------
    always_comb begin
        count_w = wptr_q - rptr_q;
        empty_w = (wptr_q == rptr_q);
        full_w  = (wptr_q[DEPTH-1:0] == rptr_q[DEPTH-1:0]) &&
                  (wptr_q[DEPTH]     != rptr_q[DEPTH]);
    end

    // -----------------------------------------------------------------------
    // Acceptance and next-state. Both acceptances use the pre-edge flags: a
    // full FIFO still drops a write even if a read frees a slot this cycle,
    // and an empty FIFO cannot return the word being written this cycle.
    // Reset wins over any request and suppresses the error pulses.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (!rst) begin
            wr_en       = we && !full_w;
            rd_en       = re && !empty_w;
            overflow_d  = we && full_w;
            underflow_d = re && empty_w;
        end

        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; after reset the pointers make its
    // old contents unreachable until they are rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[DEPTH-1:0]] <= wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read data path.
    // -----------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // Head word is visible straight from storage; meaningless when empty.
        assign rdata = mem[rptr_q[DEPTH-1:0]];
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_en) begin
                rdata_d = mem[rptr_q[DEPTH-1:0]];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_w;
    assign almost_full  = (count_w >= AFULL_LVL);
    assign almost_empty = (count_w <= AEMPTY_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo -- drives two sync_fifo instances (FWFT=1 and FWFT=0) with the
// same stimulus and compares both against a queue-based reference model on
// every cycle, plus directed scenarios with literal expectations.
// Configuration: WIDTH=8, DEPTH=2 (4 entries), AFULL_THRESH=3, AEMPTY_THRESH=1.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int N     = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we  = 1'b0;
    logic             re  = 1'b0;
    logic [WIDTH-1:0] wdata = '0;

    logic [WIDTH-1:0] rdata1, rdata0;
    logic             full1, empty1, afull1, aempty1, ovf1, unf1;
    logic             full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [DEPTH:0]   count1, count0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
        .rdata(rdata1), .full(full1), .empty(empty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                .AEMPTY_THRESH(AE), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
        .rdata(rdata0), .full(full0), .empty(empty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: contents as a queue, error pulses and the registered
    // read word as plain variables, all updated once per clock edge.
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf   = 1'b0;
    logic             m_unf   = 1'b0;
    logic [WIDTH-1:0] m_rd    = '0;
    bit               m_valid = 1'b0;

    task automatic model_step(input logic r, input logic w, input logic rd,
                              input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == N);
        was_empty = (mq.size() == 0);
        if (r) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rd    = '0;
            m_valid = 1'b1;
        end else begin
            m_ovf = w && was_full;
            m_unf = rd && was_empty;
            if (rd && !was_empty) begin
                m_rd = mq.pop_front();
            end
            if (w && !was_full) begin
                mq.push_back(d);
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then
    // settle just past the falling edge where outputs are compared.
    task automatic cycle(input logic r, input logic w, input logic rd,
                         input logic [WIDTH-1:0] d);
        rst   = r;
        we    = w;
        re    = rd;
        wdata = d;
        @(posedge clk);
        model_step(r, w, rd, d);
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            int sz;
            sz = mq.size();
            check("count_fwft",   32'(count1),  32'(sz));
            check("count_reg",    32'(count0),  32'(sz));
            check("empty_fwft",   32'(empty1),  32'(sz == 0));
            check("empty_reg",    32'(empty0),  32'(sz == 0));
            check("full_fwft",    32'(full1),   32'(sz == N));
            check("full_reg",     32'(full0),   32'(sz == N));
            check("afull_fwft",   32'(afull1),  32'(sz >= AF));
            check("afull_reg",    32'(afull0),  32'(sz >= AF));
            check("aempty_fwft",  32'(aempty1), 32'(sz <= AE));
            check("aempty_reg",   32'(aempty0), 32'(sz <= AE));
            check("ovf_fwft",     32'(ovf1),    32'(m_ovf));
            check("ovf_reg",      32'(ovf0),    32'(m_ovf));
            check("unf_fwft",     32'(unf1),    32'(m_unf));
            check("unf_reg",      32'(unf0),    32'(m_unf));
            check("rdata_reg",    32'(rdata0),  32'(m_rd));
            if (sz != 0) begin
                check("rdata_fwft", 32'(rdata1), 32'(mq[0]));
            end
        end
    end

    logic [WIDTH-1:0] exp_words [4];

    initial begin
        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("lit_reset_count",  32'(count1),  32'd0);
        check("lit_reset_empty",  32'(empty1),  32'd1);
        check("lit_reset_aempty", 32'(aempty1), 32'd1);
        check("lit_reset_full",   32'(full1),   32'd0);
        check("lit_reset_afull",  32'(afull1),  32'd0);
        check("lit_reset_rdreg",  32'(rdata0),  32'd0);

        // Fill to full.
        exp_words[0] = 8'h11; exp_words[1] = 8'h22;
        exp_words[2] = 8'h33; exp_words[3] = 8'h44;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, exp_words[i]);
        check("lit_fill_full",  32'(full1),  32'd1);
        check("lit_fill_count", 32'(count1), 32'd4);
        check("lit_fill_afull", 32'(afull1), 32'd1);
        check("lit_fill_empty", 32'(empty1), 32'd0);
        check("lit_fill_head",  32'(rdata1), 32'h11);

        // Overflow from full, then drain in order.
        cycle(1'b0, 1'b1, 1'b0, 8'h55);
        check("lit_ovf_pulse", 32'(ovf1),   32'd1);
        check("lit_ovf_count", 32'(count1), 32'd4);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("lit_ovf_clear", 32'(ovf1),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check("lit_drain_head", 32'(rdata1), 32'(exp_words[i]));
            cycle(1'b0, 1'b0, 1'b1, '0);
            check("lit_drain_reg", 32'(rdata0), 32'(exp_words[i]));
        end
        check("lit_drain_empty", 32'(empty1), 32'd1);

        // Underflow from empty.
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("lit_unf_pulse", 32'(unf1),   32'd1);
        check("lit_unf_count", 32'(count1), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("lit_unf_clear", 32'(unf1),   32'd0);

        // Interleaved write/read across the pointer wrap.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
            check("lit_wrap_head", 32'(rdata1), 32'(8'h60 + i));
            cycle(1'b0, 1'b0, 1'b1, '0);
        end

        // Sustained simultaneous write and read at count 2.
        cycle(1'b0, 1'b1, 1'b0, 8'h70);
        cycle(1'b0, 1'b1, 1'b0, 8'h71);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(8'h72 + i));
            check("lit_stream_count", 32'(count1), 32'd2);
            check("lit_stream_head",  32'(rdata1), 32'(8'h71 + i));
            check("lit_stream_reg",   32'(rdata0), 32'(8'h70 + i));
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Registered read: word appears after the read edge and holds.
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("lit_reg_read", 32'(rdata0), 32'hA5);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("lit_reg_hold", 32'(rdata0), 32'hA5);

        // Simultaneous write+read on empty: write wins, underflow pulses.
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        check("lit_empty_wr_count", 32'(count1), 32'd1);
        check("lit_empty_wr_unf",   32'(unf1),   32'd1);

        // Reset beats requests at count 3.
        cycle(1'b0, 1'b1, 1'b0, 8'h3D);
        cycle(1'b0, 1'b1, 1'b0, 8'h3E);
        check("lit_pre_rst_count", 32'(count1), 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 8'h77);
        check("lit_rst_count", 32'(count1), 32'd0);
        check("lit_rst_empty", 32'(empty1), 32'd1);
        check("lit_rst_ovf",   32'(ovf1),   32'd0);
        check("lit_rst_unf",   32'(unf1),   32'd0);

        // Randomized traffic with shifting write/read bias.
        begin
            int wp;
            int rp;
            wp = 50;
            rp = 50;
            for (int i = 0; i < 3000; i++) begin
                if (i % 200 == 0) begin
                    wp = 20 + 30 * int'($urandom_range(0, 2));
                    rp = 20 + 30 * int'($urandom_range(0, 2));
                end
                cycle($urandom_range(0, 99) == 0,
                      int'($urandom_range(0, 99)) < wp,
                      int'($urandom_range(0, 99)) < rp,
                      8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, address width; storage holds 2**DEPTH words.
REQ-003 SHALL have parameter AFULL_THRESH, default 2**DEPTH-1, almost_full level; legal range 1..2**DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1, almost_empty level; legal range 0..2**DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port we, input, 1, write request.
REQ-009 SHALL have port wdata, input, WIDTH, write data.
REQ-010 SHALL have port re, input, 1, read request.
REQ-011 SHALL have port rdata, output, WIDTH, read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty, output, 1 each, status flags.
REQ-013 SHALL have port count, output, DEPTH+1, current occupancy 0..2**DEPTH.
REQ-014 SHALL have ports overflow, underflow, output, 1 each, single-cycle error pulses.

Function
REQ-015 SHALL keep write and read pointers of DEPTH+1 bits; low DEPTH bits address storage, MSB is wrap bit; pointers wrap modulo 2**(DEPTH+1).
REQ-016 SHALL accept a write iff we && !full at the clock edge: mem[wptr] <= wdata, wptr increments.
REQ-017 SHALL accept a read iff re && !empty at the clock edge: rptr increments.
REQ-018 SHALL evaluate both acceptances from pre-edge flags; no write-through when full, no read of same-cycle write when empty.
REQ-019 SHALL drive count = wptr - rptr (DEPTH+1-bit modular subtraction), registered-state based.
REQ-020 SHALL assert empty iff wptr == rptr; full iff low DEPTH bits equal and MSBs differ.
REQ-021 SHALL assert almost_full iff count >= AFULL_THRESH; almost_empty iff count <= AEMPTY_THRESH.
REQ-022 SHALL assert overflow for exactly the cycle after an edge where we && full; underflow likewise for re && empty.
REQ-023 Simultaneous accepted write and read SHALL leave count unchanged and move both pointers.
REQ-024 When full with we && re: read accepted, write dropped, count becomes 2**DEPTH-1, overflow pulses.
REQ-025 When empty with we && re: write accepted, read dropped, count becomes 1, underflow pulses.
REQ-026 FWFT=1: rdata SHALL combinationally equal mem[rptr[DEPTH-1:0]]; valid whenever !empty; don't-care when empty.
REQ-027 FWFT=0: rdata SHALL be a register loaded with mem[rptr] on an accepted read (available the cycle after the edge) and hold otherwise.
REQ-028 Storage SHALL be 2**DEPTH x WIDTH, written only by accepted writes, not reset.

Reset
REQ-029 rst high at an edge SHALL set wptr=rptr=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, FWFT=0 rdata register=0.
REQ-030 rst SHALL take priority over we/re in the same cycle; those requests are neither accepted nor flagged as errors.
REQ-031 Reset mid-operation SHALL discard all stored words logically; storage contents are not cleared and not readable until rewritten.

Verification (WIDTH=8, DEPTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-032 Reset then write 0x11,0x22,0x33,0x44 on 4 cycles -> full=1, count=4, almost_full=1, empty=0; FWFT=1 rdata=0x11.
REQ-033 From full, we=1 wdata=0x55 one cycle -> overflow pulses one cycle, count stays 4; then 4 reads return 0x11,0x22,0x33,0x44, empty=1.
REQ-034 From empty, re=1 one cycle -> underflow pulses one cycle, count stays 0, pointers unchanged.
REQ-035 Write 6, read 6 interleaved (pointer wrap) then we&&re sustained 8 cycles at count=2 -> data order preserved, count constant 2, no error pulses.
REQ-036 FWFT=0: write 0xA5, read one cycle -> rdata=0xA5 the cycle after the read edge and holds while re=0.
REQ-037 Count=3 with rst=1, we=1, re=1 same cycle -> next cycle count=0, empty=1, overflow=0, underflow=0.
